uart_bank_ext: RTL
==================

UART_BANK_EXT -- requirements
Module: uart_bank_ext

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: PHY FIFO depth, power of two, >= 2; CW = $clog2(FIFO_DEPTH).
REQ-002 SHALL have parameter CLOCK_FREQ_HZ, default 10000000: sets DivInit = CLOCK_FREQ_HZ/115200 - 1.
REQ-003 SHALL have parameter DATA_WIDTH, default 8: character width DW, legal 5..9.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clock  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-low (0 = reset).
REQ-006 addr  in  4  register word index.
REQ-007 wr_data  in  32  write data.
REQ-008 wr_en  in  1  one-cycle write strobe.
REQ-009 rd_en  in  1  one-cycle read strobe.
REQ-010 rd_data  out  32  read data, valid only while rd_valid=1.
REQ-011 rd_valid  out  1  one-cycle read response.
REQ-012 interrupt  out  1  registered interrupt line.
REQ-013 txen / nstop  out  1 each  TX enable / two stop bits.
REQ-014 txcnt  out  CW  TX watermark.
REQ-015 rxen  out  1  RX enable.
REQ-016 rxcnt  out  CW  RX watermark.
REQ-017 div  out  16  baud divisor.
REQ-018 lcr  out  2  {parity_odd, parity_en}.
REQ-019 tx_fifo_wr_en  out  1  TX FIFO push pulse.
REQ-020 tx_fifo_wr_data  out  DW  TX FIFO push data.
REQ-021 tx_fifo_full / tx_fifo_less_than_watermark  in  1 each  TX FIFO status.
REQ-022 rx_fifo_rd_en  out  1  RX FIFO pop pulse; FIFO data valid the following cycle.
REQ-023 rx_fifo_rd_data  in  DW  RX FIFO head data.
REQ-024 rx_fifo_empty / rx_fifo_full / rx_fifo_greater_than_watermark  in  1 each  RX FIFO status.
REQ-025 rx_fifo_wr_en  in  1  PHY push attempt into RX FIFO.
REQ-026 rx_err  in  2  one-cycle pulses {frame, parity} from PHY.
REQ-027 baud_tick  in  1  one-cycle pulse per bit time.

Function
REQ-028 Register map SHALL be, by addr: 0 TXDATA (W: data[DW-1:0]; R: bit31 = tx_fifo_full); 1 RXDATA (R: bit31 = empty, data[DW-1:0]); 2 TXCTRL (txen[0], nstop[1], txcnt[16+CW-1:16]); 3 RXCTRL (rxen[0], rxcnt[16+CW-1:16]); 4 IE[3:0]; 5 IP[3:0] read-only; 6 DIV[15:0]; 7 LCR[1:0]; 8 ERR[2:0] W1C; 9 RXTO[7:0]; 10-15 read 0, writes ignored; unused bits read 0.
REQ-029 IP/IE bits SHALL be: 0 tx_fifo_less_than_watermark, 1 rx_fifo_greater_than_watermark, 2 ERR != 0, 3 timeout flag; interrupt SHALL be the register of |(IP & IE), updated one cycle after the cause.
REQ-030 TXDATA write SHALL pulse tx_fifo_wr_en the next cycle with registered data only if tx_fifo_full=0 at the write; a write while full SHALL be dropped.
REQ-031 Read FSM SHALL be IDLE, POP, LATCH, RESP; non-RXDATA read: IDLE->RESP, rd_valid 1 cycle after rd_en; RXDATA read with rx_fifo_empty=0: IDLE->POP (rx_fifo_rd_en=1)->LATCH (capture rx_fifo_rd_data)->RESP, rd_valid 3 cycles after rd_en; RXDATA read when empty: IDLE->RESP, returns bit31=1 with last captured data, no pop.
REQ-032 rd_en/wr_en SHALL be accepted only in IDLE and ignored otherwise; simultaneous rd_en and wr_en SHALL process the write only.
REQ-033 ERR SHALL set bit0 on rx_err[0], bit1 on rx_err[1], bit2 on rx_fifo_wr_en while rx_fifo_full=1; W1C writes clear; a set event in the clearing cycle SHALL win.
REQ-034 Timeout counter (8-bit) SHALL clear on rx_fifo_wr_en, on any pop, or when rx_fifo_empty=1; otherwise increment on baud_tick, saturating; flag sets when count == 10*RXTO... implemented as count reaching RXTO with baud_tick prescaled by 10 (one character time); RXTO=0 disables.
REQ-035 Timeout flag SHALL stay set until an RXDATA pop or rx_fifo_empty=1.

Reset
REQ-036 reset=0 SHALL force: FSM IDLE, rd_valid/rx_fifo_rd_en/tx_fifo_wr_en/interrupt 0, TXDATA/RXDATA/TXCTRL/RXCTRL/IE/LCR/ERR/RXTO 0, counters 0, DIV = DivInit; a pending read is abandoned with no rd_valid.

Structure
REQ-037 Address enum, IP bit indices and DivInit formula SHALL live in the shared uart package.
REQ-038 Timeout logic SHALL be sub-module uart_rx_timeout (prescaler + counter + flag).

Verification
REQ-039 Reset: read DIV with CLOCK_FREQ_HZ=10000000 -> rd_data=86, rd_valid 1 cycle after rd_en.
REQ-040 RX FIFO holding 0x5A, read addr 1 -> one rx_fifo_rd_en pulse, rd_valid at +3, rd_data=0x0000005A; second read when empty -> 0x8000005A, no pop.
REQ-041 TXDATA write 0x41 while full=0 -> tx_fifo_wr_en at +1 with data 0x41; write while full=1 -> no push.
REQ-042 rx_err[0] pulse and a write of 1 to ERR in the same cycle -> ERR[0] stays 1; IE=4 -> interrupt=1 one cycle later.
REQ-043 RXTO=2, FIFO non-empty, no pushes -> flag sets after 20 baud_ticks; RXDATA pop clears it.
REQ-044 Assert reset=0 during POP -> rd_valid never asserted, FSM IDLE after release.

Source files
------------

// File: rtl/uart_bank_ext_pkg.sv
// Shared UART register-bank definitions: register address map, interrupt
// bit positions, read FSM states and the reset baud divisor.
package uart_bank_ext_pkg;

  typedef enum logic [3:0] {
    A_TXDATA = 4'd0,
    A_RXDATA = 4'd1,
    A_TXCTRL = 4'd2,
    A_RXCTRL = 4'd3,
    A_IE     = 4'd4,
    A_IP     = 4'd5,
    A_DIV    = 4'd6,
    A_LCR    = 4'd7,
    A_ERR    = 4'd8,
    A_RXTO   = 4'd9
  } addr_e;

  localparam int IP_TXWM = 0;
  localparam int IP_RXWM = 1;
  localparam int IP_ERR  = 2;
  localparam int IP_TO   = 3;

  localparam int unsigned BAUD = 115200;

  typedef enum logic [1:0] {S_IDLE, S_POP, S_LATCH, S_RESP} rd_state_e;

  // CLOCK_FREQ_HZ/115200 - 1 with the quotient rounded to nearest, so a
  // 10 MHz clock (86.8 clocks per bit) yields 86 rather than truncating to 85.
  function automatic logic [15:0] div_init(input int unsigned freq);
    return 16'((freq + BAUD / 2) / BAUD - 1);
  endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// RX idle timeout. baud_tick is prescaled by 10 (one character time) and
// counted in a saturating 8-bit counter; the flag is raised once the count
// reaches rxto (rxto = 0 disables) and is held until flag_clr.
// Ports: clock/reset, baud_tick, clear (restart count), flag_clr,
//        rxto threshold in characters, flag out.
module uart_rx_timeout (
  input  logic       clock,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic       clear,
  input  logic       flag_clr,
  input  logic [7:0] rxto,
  output logic       flag
);

  logic [3:0] pre;
  logic [7:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre  <= '0;
      cnt  <= '0;
      flag <= 1'b0;
    end else begin
      if (clear) begin
        pre <= '0;
        cnt <= '0;
      end else if (baud_tick) begin
        if (pre == 4'd9) begin
          pre <= '0;
          if (cnt != 8'hFF) cnt <= cnt + 8'd1;
        end else begin
          pre <= pre + 4'd1;
        end
      end
      // clear beats set so a pop never re-arms off the stale count
      if (flag_clr)                        flag <= 1'b0;
      else if (rxto != '0 && cnt >= rxto)  flag <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_bank_ext.sv
// UART control/status register bank sitting between a simple register bus
// and the UART PHY/FIFOs. Reads go through a small FSM so RXDATA reads can
// pop the RX FIFO and wait for its data; other reads answer next cycle.
// Ports: bus (addr, wr_data, wr_en, rd_en, rd_data, rd_valid), interrupt,
//        control outputs (txen, nstop, txcnt, rxen, rxcnt, div, lcr),
//        TX FIFO push side, RX FIFO pop side and status, PHY error/tick.
module uart_bank_ext
  import uart_bank_ext_pkg::*;
#(
  parameter  int FIFO_DEPTH    = 8,
  parameter  int CLOCK_FREQ_HZ = 10000000,
  parameter  int DATA_WIDTH    = 8,
  localparam int CW            = $clog2(FIFO_DEPTH),
  localparam int DW            = DATA_WIDTH
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [3:0]    addr,
  input  logic [31:0]   wr_data,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic [31:0]   rd_data,
  output logic          rd_valid,
  output logic          interrupt,
  output logic          txen,
  output logic          nstop,
  output logic [CW-1:0] txcnt,
  output logic          rxen,
  output logic [CW-1:0] rxcnt,
  output logic [15:0]   div,
  output logic [1:0]    lcr,
  output logic          tx_fifo_wr_en,
  output logic [DW-1:0] tx_fifo_wr_data,
  input  logic          tx_fifo_full,
  input  logic          tx_fifo_less_than_watermark,
  output logic          rx_fifo_rd_en,
  input  logic [DW-1:0] rx_fifo_rd_data,
  input  logic          rx_fifo_empty,
  input  logic          rx_fifo_full,
  input  logic          rx_fifo_greater_than_watermark,
  input  logic          rx_fifo_wr_en,
  input  logic [1:0]    rx_err,
  input  logic          baud_tick
);

  rd_state_e     state, state_n;
  logic          wr_acc, rd_acc;
  logic [3:0]    ie, ip;
  logic [2:0]    err, err_set, err_clr;
  logic [7:0]    rxto;
  logic [DW-1:0] rx_data;
  logic [31:0]   rd_q, rd_mux;
  logic          to_flag;
  logic          unused_wr;

  assign unused_wr = ^wr_data;

  // bus is only accepted in IDLE; a write wins over a simultaneous read
  assign wr_acc = wr_en && (state == S_IDLE);
  assign rd_acc = rd_en && !wr_en && (state == S_IDLE);

  assign ip[IP_TXWM] = tx_fifo_less_than_watermark;
  assign ip[IP_RXWM] = rx_fifo_greater_than_watermark;
  assign ip[IP_ERR]  = |err;
  assign ip[IP_TO]   = to_flag;

  assign err_set = {rx_fifo_wr_en & rx_fifo_full, rx_err[1], rx_err[0]};
  assign err_clr = (wr_acc && addr == A_ERR) ? wr_data[2:0] : 3'b0;
  assign rd_data = rd_q;

  always_comb begin
    rd_mux = '0;
    case (addr)
      A_TXDATA: rd_mux[31] = tx_fifo_full;
      A_RXDATA: begin
        // only reached for the empty case; the pop path reloads rd_q in LATCH
        rd_mux[31]     = rx_fifo_empty;
        rd_mux[DW-1:0] = rx_data;
      end
      A_TXCTRL: begin
        rd_mux[0]       = txen;
        rd_mux[1]       = nstop;
        rd_mux[16 +: CW] = txcnt;
      end
      A_RXCTRL: begin
        rd_mux[0]        = rxen;
        rd_mux[16 +: CW] = rxcnt;
      end
      A_IE:    rd_mux[3:0]  = ie;
      A_IP:    rd_mux[3:0]  = ip;
      A_DIV:   rd_mux[15:0] = div;
      A_LCR:   rd_mux[1:0]  = lcr;
      A_ERR:   rd_mux[2:0]  = err;
      A_RXTO:  rd_mux[7:0]  = rxto;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n       = state;
    rx_fifo_rd_en = 1'b0;
    rd_valid      = 1'b0;
    case (state)
      S_IDLE:  if (rd_acc) state_n = (addr == A_RXDATA && !rx_fifo_empty) ? S_POP : S_RESP;
      S_POP:   begin rx_fifo_rd_en = 1'b1; state_n = S_LATCH; end
      S_LATCH: state_n = S_RESP;
      S_RESP:  begin rd_valid = 1'b1; state_n = S_IDLE; end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_q            <= '0;
      rx_data         <= '0;
      tx_fifo_wr_en   <= 1'b0;
      tx_fifo_wr_data <= '0;
      txen            <= 1'b0;
      nstop           <= 1'b0;
      txcnt           <= '0;
      rxen            <= 1'b0;
      rxcnt           <= '0;
      ie              <= '0;
      div             <= div_init(CLOCK_FREQ_HZ);
      lcr             <= '0;
      err             <= '0;
      rxto            <= '0;
      interrupt       <= 1'b0;
    end else begin
      interrupt     <= |(ip & ie);
      err           <= (err & ~err_clr) | err_set;
      tx_fifo_wr_en <= wr_acc && addr == A_TXDATA && !tx_fifo_full;

      if (rd_acc) begin
        rd_q <= rd_mux;
      end else if (state == S_LATCH) begin
        rd_q    <= 32'(rx_fifo_rd_data);
        rx_data <= rx_fifo_rd_data;
      end

      if (wr_acc) begin
        case (addr)
          A_TXDATA: if (!tx_fifo_full) tx_fifo_wr_data <= wr_data[DW-1:0];
          A_TXCTRL: begin
            txen  <= wr_data[0];
            nstop <= wr_data[1];
            txcnt <= wr_data[16 +: CW];
          end
          A_RXCTRL: begin
            rxen  <= wr_data[0];
            rxcnt <= wr_data[16 +: CW];
          end
          A_IE:    ie   <= wr_data[3:0];
          A_DIV:   div  <= wr_data[15:0];
          A_LCR:   lcr  <= wr_data[1:0];
          A_RXTO:  rxto <= wr_data[7:0];
          default: ;
        endcase
      end
    end
  end

  uart_rx_timeout u_timeout (
    .clock     (clock),
    .reset     (reset),
    .baud_tick (baud_tick),
    .clear     (rx_fifo_wr_en | rx_fifo_rd_en | rx_fifo_empty),
    .flag_clr  (rx_fifo_rd_en | rx_fifo_empty),
    .rxto      (rxto),
    .flag      (to_flag)
  );

endmodule
